mvt_operand_stream: RTL and testbench
=====================================

# mvt_operand_stream

Operand sequencer feeding the MVT multiply-accumulate stage. Reads matrix A and vector y from two synchronous-read memories and emits one `(aout, y_out)` pair per cycle, row by row. Normal or transposed traversal is selected per run. Inserts the clear beat (`y_out = 0`) that resets the downstream accumulator before each row. Drives `y_out` with a hold code whenever it has nothing to deliver.

## Interface
- `N`, 4: matrix dimension; A is N×N, y has N entries
- `DW`, 32: data width of A, y, `aout`, `y_out`
- `AW`, 8: memory address width; must satisfy 2^AW ≥ N*N
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a run when idle
- `transpose`  in  1  sampled with `start`; 0 streams A[i][j], 1 streams A[j][i]
- `a_addr`  out  AW  A memory read address
- `a_rd_en`  out  1  A memory read enable
- `a_rdata`  in  DW  A read data, valid the cycle after `a_rd_en`
- `y_addr`  out  AW  y memory read address
- `y_rd_en`  out  1  y memory read enable
- `y_rdata`  in  DW  y read data, valid the cycle after `y_rd_en`
- `aout`  out  DW  matrix operand to the MAC stage (registered)
- `y_out`  out  DW  vector operand to the MAC stage (registered)
- `row_last`  out  1  high on the last element beat of each row
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the final beat of the run
- `range_err`  out  1  sticky; set if any y entry read during the run is ≥ 100

## Operation
- Downstream contract:
  - `y_out = 0` clears the accumulator.
  - 1 ≤ `y_out` < 100 accumulates `aout*y_out`.
  - `y_out` ≥ 100 leaves the accumulator unchanged. HOLD_Y = 100 is used as the no-op code.
- FSM states:
  - IDLE → CLR on `start`.
  - CLR → RUN.
  - RUN loops for N columns, then returns to CLR for the next row. After row N-1 it goes to FIN.
  - FIN → IDLE, asserting `done`.
- Beats per row: one clear beat (`aout=0`, `y_out=0`), then N element beats j=0..N-1. Rows are back-to-back with no bubbles. A run is N*(N+1) beats.
- Addressing for row i, column j:
  - `transpose`=0: A address i*N+j.
  - `transpose`=1: A address j*N+i.
  - y address: j.
  - `a_rd_en` and `y_rd_en` are asserted together, one read per element beat.
- Zero y entry: if `y_rdata` = 0, that element beat outputs `y_out` = HOLD_Y and `aout` = 0. This prevents a false clear; the product would have been 0 anyway.
- y entry ≥ 100: it is emitted unchanged, so the MAC skips it. `range_err` is set.
- `range_err` clears on an accepted `start`.
- `start` while `busy`: ignored. `transpose` is latched only on an accepted `start`.
- Outside a run: `aout`=0, `y_out`=HOLD_Y, `row_last`=0, read enables 0.

## Timing
- Reset values:
  - `aout`=0, `y_out`=HOLD_Y, `row_last`=0, `busy`=0, `done`=0, `range_err`=0.
  - `a_rd_en`=`y_rd_en`=0, addresses 0, FSM=IDLE.
- `start` sampled at edge t: `busy`=1 from t+1. The first clear beat is on the outputs at t+2.
- The first read issues so that element beat j=0 follows the clear beat with no gap. Each read leads its output beat by the 1-cycle memory latency plus the output register.
- Last beat of the run at t+1+N*(N+1). `done` pulses in the next cycle, with `busy` falling in that same cycle.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). No partial beats follow after release.

## Structure
- Package `mvt_pkg`: HOLD_Y, CLR_Y (=0), and the FSM state enum {IDLE, CLR, RUN, FIN}. The MAC stage also uses HOLD_Y from this package.
- One sub-module, `mvt_addr_gen`:
  - Row/column counters with wrap at N-1.
  - Transpose address mux.
  - `last_col`/`last_row` flags.
- The top level holds the FSM, the read-data pipeline register, the zero-y substitution and `range_err`.

## Test plan
- Normal run, N=4, A[i][j]=i*4+j+1, y={1,2,3,4}:
  - Beats are clear, (1,1), (2,2), (3,3), (4,4), then clear, (5,1), …
  - A behavioural MAC ends rows with x = 30, 70, 110, 150.
- Same data with `transpose`=1:
  - Row 0 beats are (1,1), (5,2), (9,3), (13,4).
  - x = 90, 100, 110, 120.
- y={0,2,0,4}:
  - Beats j=0 and j=2 show `y_out`=100, `aout`=0. No extra clears.
  - Row 0 x = 2*2+4*4 = 20. `range_err`=0.
- y={1,150,1,1}: beat j=1 shows `y_out`=150; `range_err`=1 and stays set until the next `start`.
- `start` pulsed again 5 cycles into a run: ignored. The run completes in 2+20 cycles and `done` pulses once.
- `rst_n` dropped at beat 7:
  - Outputs are 0/HOLD_Y immediately.
  - After release, idle until the next `start`, then a full clean run.

Source files
------------

// File: rtl/mvt_pkg.sv
// Shared constants and FSM state type for the MVT operand path.
// HOLD_Y is also the no-op code the MAC stage recognises.
package mvt_pkg;
    localparam int unsigned HOLD_Y = 100;
    localparam int unsigned CLR_Y  = 0;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        FIN
    } mvt_state_e;
endpackage

// File: rtl/mvt_addr_gen.sv
// Row/column read counters for the operand stream, with the transpose
// address mux and last-row/last-column flags for the read position.
module mvt_addr_gen
    import mvt_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic          transpose,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] y_addr,
    output logic          last_col,
    output logic          last_row
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [AW-1:0] row_w;
    logic [AW-1:0] col_w;

    // Counters always point at the read being issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (clear) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (advance) begin
            if (col_reg == LAST) begin
                col_reg <= '0;
                row_reg <= (row_reg == LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign last_col = (col_reg == LAST);
    assign last_row = (row_reg == LAST);

    assign row_w  = AW'(row_reg);
    assign col_w  = AW'(col_reg);
    assign a_addr = transpose ? (col_w * AW'(N) + row_w) : (row_w * AW'(N) + col_w);
    assign y_addr = col_w;
endmodule

// File: rtl/mvt_operand_stream.sv
// Operand sequencer for the MVT MAC: streams a clear beat then N (A, y)
// element beats per row, normal or transposed, with zero-y substitution.
module mvt_operand_stream
    import mvt_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          transpose,
    output logic [AW-1:0] a_addr,
    output logic          a_rd_en,
    input  logic [DW-1:0] a_rdata,
    output logic [AW-1:0] y_addr,
    output logic          y_rd_en,
    input  logic [DW-1:0] y_rdata,
    output logic [DW-1:0] aout,
    output logic [DW-1:0] y_out,
    output logic          row_last,
    output logic          busy,
    output logic          done,
    output logic          range_err
);
    localparam logic [DW-1:0] HOLD_V = DW'(HOLD_Y);
    localparam logic [DW-1:0] CLR_V  = DW'(CLR_Y);

    mvt_state_e    state_reg;
    logic          rd_en_reg;
    logic          fin_pending_reg;
    logic          transpose_reg;
    logic [DW-1:0] aout_reg;
    logic [DW-1:0] y_out_reg;
    logic          row_last_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          range_err_reg;
    logic          accept;
    logic          last_col;
    logic          last_row;

    assign accept = (state_reg == IDLE) && start;

    mvt_addr_gen #(
        .N  (N),
        .AW (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .advance   (rd_en_reg),
        .transpose (transpose_reg),
        .a_addr    (a_addr),
        .y_addr    (y_addr),
        .last_col  (last_col),
        .last_row  (last_row)
    );

    // The read for element j is issued one cycle before the RUN cycle that
    // captures it, so the CLR cycle already reads column 0 of its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rd_en_reg       <= 1'b0;
            fin_pending_reg <= 1'b0;
            transpose_reg   <= 1'b0;
            aout_reg        <= '0;
            y_out_reg       <= HOLD_V;
            row_last_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            range_err_reg   <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            row_last_reg <= 1'b0;
            aout_reg     <= '0;
            y_out_reg    <= HOLD_V;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg       <= CLR;
                        busy_reg        <= 1'b1;
                        rd_en_reg       <= 1'b1;
                        fin_pending_reg <= 1'b0;
                        range_err_reg   <= 1'b0;
                        transpose_reg   <= transpose;
                    end
                end
                CLR, RUN: begin
                    if (state_reg == CLR) begin
                        y_out_reg <= CLR_V;
                    end else begin
                        // A zero y would look like a clear downstream; emit a no-op instead.
                        if (y_rdata == '0) begin
                            y_out_reg <= HOLD_V;
                        end else begin
                            aout_reg  <= a_rdata;
                            y_out_reg <= y_rdata;
                        end
                        if (y_rdata >= HOLD_V) begin
                            range_err_reg <= 1'b1;
                        end
                        row_last_reg <= !rd_en_reg;
                    end
                    if (rd_en_reg) begin
                        state_reg <= RUN;
                        if (last_col) begin
                            rd_en_reg       <= 1'b0;
                            fin_pending_reg <= last_row;
                        end
                    end else if (fin_pending_reg) begin
                        state_reg <= FIN;
                    end else begin
                        state_reg <= CLR;
                        rd_en_reg <= 1'b1;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign a_rd_en   = rd_en_reg;
    assign y_rd_en   = rd_en_reg;
    assign aout      = aout_reg;
    assign y_out     = y_out_reg;
    assign row_last  = row_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign range_err = range_err_reg;
endmodule

// File: tb/tb_mvt_operand_stream.sv
// Randomised scoreboard bench for mvt_operand_stream with a behavioural
// matrix/vector model and a behavioural downstream MAC.
module tb_mvt_operand_stream;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RUN_CYCLES = N * (N + 1) + 2;

    typedef struct {
        longint a;
        longint y;
        longint last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          transpose;
    logic [AW-1:0] a_addr;
    logic          a_rd_en;
    logic [DW-1:0] a_rdata;
    logic [AW-1:0] y_addr;
    logic          y_rd_en;
    logic [DW-1:0] y_rdata;
    logic [DW-1:0] aout;
    logic [DW-1:0] y_out;
    logic          row_last;
    logic          busy;
    logic          done;
    logic          range_err;

    logic [DW-1:0] a_mem [N*N];
    logic [DW-1:0] y_mem [N];

    beat_t  exp_q[$];
    longint x_q[$];
    int     total = 0;
    int     bad   = 0;
    logic   busy_prev = 1'b0;
    longint acc = 0;

    mvt_operand_stream #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .transpose (transpose),
        .a_addr    (a_addr),
        .a_rd_en   (a_rd_en),
        .a_rdata   (a_rdata),
        .y_addr    (y_addr),
        .y_rd_en   (y_rd_en),
        .y_rdata   (y_rdata),
        .aout      (aout),
        .y_out     (y_out),
        .row_last  (row_last),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External synchronous-read memories
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= a_mem[a_addr];
        if (y_rd_en) y_rdata <= y_mem[y_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a beat is on the outputs on every busy cycle but the first.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            acc = 0;
        end else begin
            if (busy && busy_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got aout=%0d y_out=%0d expected none", aout, y_out);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_aout", longint'(aout), e.a);
                    check("beat_y_out", longint'(y_out), e.y);
                    check("beat_row_last", longint'(row_last), e.last);
                end
                if (y_out == 0) acc = 0;
                else if (y_out < 100) acc += longint'(aout) * longint'(y_out);
                if (row_last) begin
                    if (x_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_row_end: got x=%0d expected none", acc);
                    end else begin
                        check("row_sum", acc, x_q.pop_front());
                    end
                end
            end
            busy_prev = busy;
        end
    end

    // Reference: one clear beat per row, then the N products of that row.
    task automatic push_run(input bit tr);
        for (int i = 0; i < N; i++) begin
            longint sum;
            sum = 0;
            exp_q.push_back('{a: 0, y: 0, last: 0});
            for (int j = 0; j < N; j++) begin
                longint av;
                longint yv;
                av = tr ? longint'(a_mem[j*N+i]) : longint'(a_mem[i*N+j]);
                yv = longint'(y_mem[j]);
                if (yv == 0) exp_q.push_back('{a: 0, y: 100, last: (j == N-1)});
                else         exp_q.push_back('{a: av, y: yv, last: (j == N-1)});
                if (yv != 0 && yv < 100) sum += av * yv;
            end
            x_q.push_back(sum);
        end
    endtask

    task automatic do_run(input bit tr, input int extra_k);
        bit exp_err;
        bit got;
        exp_err = 1'b0;
        for (int j = 0; j < N; j++) if (y_mem[j] >= 100) exp_err = 1'b1;
        push_run(tr);
        start = 1'b1;
        transpose = tr;
        @(negedge clk);
        start = 1'b0;
        transpose = 1'($urandom_range(0, 1));
        check("busy_rise", longint'(busy), 1);
        check("range_err_clear", longint'(range_err), 0);
        got = 1'b0;
        for (int k = 2; k <= 60 && !got; k++) begin
            start = (k == extra_k);
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("done_time", k, RUN_CYCLES);
                check("busy_fall", longint'(busy), 0);
            end
        end
        start = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", RUN_CYCLES);
        end
        check("range_err", longint'(range_err), longint'(exp_err));
        check("beats_left", exp_q.size(), 0);
        check("rows_left", x_q.size(), 0);
        exp_q.delete();
        x_q.delete();
        @(negedge clk);
        check("done_pulse", longint'(done), 0);
    endtask

    task automatic load_a_seq();
        for (int i = 0; i < N*N; i++) a_mem[i] = DW'(i + 1);
    endtask

    task automatic load_y(input int y0, input int y1, input int y2, input int y3);
        y_mem[0] = DW'(y0);
        y_mem[1] = DW'(y1);
        y_mem[2] = DW'(y2);
        y_mem[3] = DW'(y3);
    endtask

    task automatic load_random();
        for (int i = 0; i < N*N; i++) a_mem[i] = DW'($urandom_range(0, 255));
        for (int j = 0; j < N; j++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      y_mem[j] = '0;
            else if (sel == 1) y_mem[j] = DW'($urandom_range(100, 130));
            else               y_mem[j] = DW'($urandom_range(1, 99));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_aout"}, longint'(aout), 0);
        check({tag, "_y_out"}, longint'(y_out), 100);
        check({tag, "_row_last"}, longint'(row_last), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_rd_en"}, longint'({a_rd_en, y_rd_en}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        transpose = 1'b0;
        load_a_seq();
        load_y(1, 2, 3, 4);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_range_err", longint'(range_err), 0);
        check("reset_addr", longint'({a_addr, y_addr}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle");

        do_run(1'b0, -1);
        do_run(1'b1, -1);
        load_y(0, 2, 0, 4);
        do_run(1'b0, -1);
        load_y(1, 150, 1, 1);
        do_run(1'b0, -1);
        repeat (3) @(negedge clk);
        check("range_err_sticky", longint'(range_err), 1);
        load_y(1, 2, 3, 4);
        do_run(1'b1, 5);

        // Reset in the middle of beat 7 of a run
        push_run(1'b0);
        start = 1'b1;
        transpose = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        x_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_idle_outputs("post_reset");
        end
        do_run(1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            load_random();
            do_run(1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
